uart_rx_buffer: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receive FSM. It takes each completed 10-bit frame strobed out by the receiver, checks its start and stop bits, and extracts the data byte. Good bytes go into a first-word-fall-through FIFO, which the host logic drains through a valid/ready handshake. Framing errors and overflow are reported as sticky flags plus a saturating error counter.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_byte_fifo.sv | 78 +++++++
 rtl/uart_rx_buffer.sv | 75 +++++++
 tb/tb_uart_rx_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: frame field positions, error counter width
// and frame decode helpers.
`timescale 1ns/1ps
package uart_pkg;

   localparam int FRAME_W   = 10;
   localparam int START_BIT = 0;
   localparam int DATA_LSB  = 1;
   localparam int DATA_MSB  = 8;
   localparam int STOP_BIT  = 9;
   localparam int FERR_W    = 8;

   localparam logic [FERR_W-1:0] FERR_MAX = '1;

   typedef logic [FRAME_W-1:0] frame_t;
   typedef logic [DATA_MSB-DATA_LSB:0] byte_t;

   function automatic logic frame_ok(input frame_t f);
      return !f[START_BIT] && f[STOP_BIT];
   endfunction

   function automatic byte_t frame_data(input frame_t f);
      return f[DATA_MSB:DATA_LSB];
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte FIFO with a registered head (RD_DATA/RD_VALID).
// Full and empty are derived from the occupancy count, not pointer equality.
`timescale 1ns/1ps
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        WR_EN,
   input  byte_t       WR_DATA,
   input  logic        RD_EN,
   output byte_t       RD_DATA,
   output logic        RD_VALID,
   output logic [AW:0] COUNT
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   byte_t         mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   byte_t         rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          do_wr, do_rd;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      do_rd      = RD_EN && rd_valid_q;
      do_wr      = WR_EN && ((count_q != FULL_CNT) || do_rd);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;

      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_wr && !do_rd) count_d = count_q + (AW+1)'(1);
      if (!do_wr && do_rd) count_d = count_q - (AW+1)'(1);

      rd_valid_d = (count_d != '0);
      // The new head may be the slot being written on this very edge.
      if (rd_valid_d) begin
         if (do_wr && (wr_ptr_q == rd_ptr_d)) rd_data_d = WR_DATA;
         else                                 rd_data_d = mem_q[rd_ptr_d];
      end
   end

   // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // NOTE: storage has no reset; validity is carried entirely by count_q, so RAM can be inferred.
   always_ff @(posedge CLK) begin
      if (do_wr) mem_q[wr_ptr_q] <= WR_DATA;
   end

   assign RD_DATA  = rd_data_q;
   assign RD_VALID = rd_valid_q;
   assign COUNT    = count_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: frame check, push/drop decision, sticky error flags and
// a saturating framing-error counter around a byte FIFO.
`timescale 1ns/1ps
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RX_DATA_EN,
   input  frame_t            RX_DATA_T,
   output byte_t             DOUT,
   output logic              DOUT_VALID,
   input  logic              DOUT_READY,
   output logic [AW:0]       COUNT,
   output logic              FRAME_ERR,
   output logic              OVERFLOW,
   output logic [FERR_W-1:0] FERR_CNT,
   input  logic              ERR_CLR
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic              frame_err_q, frame_err_d;
   logic              overflow_q, overflow_d;
   logic [FERR_W-1:0] ferr_cnt_q, ferr_cnt_d;
   logic [FERR_W-1:0] ferr_base;
   logic              frame_good, frame_bad;
   logic              pop_ok, push_ok, drop;

   always_comb begin
      frame_good = RX_DATA_EN && frame_ok(RX_DATA_T);
      frame_bad  = RX_DATA_EN && !frame_ok(RX_DATA_T);
      pop_ok     = DOUT_VALID && DOUT_READY;
      push_ok    = frame_good && ((COUNT != FULL_CNT) || pop_ok);
      drop       = frame_good && !push_ok;

      // A clear and a new error on the same edge: the error is kept.
      ferr_base  = ERR_CLR ? '0 : ferr_cnt_q;
      ferr_cnt_d = ferr_base;
      if (frame_bad && (ferr_base != FERR_MAX)) ferr_cnt_d = ferr_base + FERR_W'(1);
      frame_err_d = frame_bad || (frame_err_q && !ERR_CLR);
      overflow_d  = drop      || (overflow_q  && !ERR_CLR);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         ferr_cnt_q  <= '0;
      end else begin
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
         ferr_cnt_q  <= ferr_cnt_d;
      end
   end

   uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK      (CLK),
      .RST      (RST),
      .WR_EN    (push_ok),
      .WR_DATA  (frame_data(RX_DATA_T)),
      .RD_EN    (DOUT_READY),
      .RD_DATA  (DOUT),
      .RD_VALID (DOUT_VALID),
      .COUNT    (COUNT)
   );

   assign FRAME_ERR = frame_err_q;
   assign OVERFLOW  = overflow_q;
   assign FERR_CNT  = ferr_cnt_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: stimulus queues expected bytes, a
// negedge monitor compares every byte handed over on DOUT.
`timescale 1ns/1ps
module tb_uart_rx_buffer;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_DATA_EN;
   logic [9:0] RX_DATA_T;
   logic [7:0] DOUT;
   logic       DOUT_VALID;
   logic       DOUT_READY;
   logic [4:0] COUNT;
   logic       FRAME_ERR;
   logic       OVERFLOW;
   logic [7:0] FERR_CNT;
   logic       ERR_CLR;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [7:0]  exp_q[$];

   uart_rx_buffer #(.DEPTH(16)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_DATA_EN (RX_DATA_EN),
      .RX_DATA_T  (RX_DATA_T),
      .DOUT       (DOUT),
      .DOUT_VALID (DOUT_VALID),
      .DOUT_READY (DOUT_READY),
      .COUNT      (COUNT),
      .FRAME_ERR  (FRAME_ERR),
      .OVERFLOW   (OVERFLOW),
      .FERR_CNT   (FERR_CNT),
      .ERR_CLR    (ERR_CLR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] good(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   // Inputs are applied 1 ns after a rising edge, held through the next edge,
   // then returned to idle.
   task automatic drive(input logic en, input logic [9:0] fr, input logic rdy, input logic clr);
      RX_DATA_EN = en;
      RX_DATA_T  = fr;
      DOUT_READY = rdy;
      ERR_CLR    = clr;
      @(posedge CLK);
      #1;
      RX_DATA_EN = 1'b0;
      DOUT_READY = 1'b0;
      ERR_CLR    = 1'b0;
   endtask

   task automatic push_good(input logic [7:0] b, input logic rdy);
      exp_q.push_back(b);
      drive(1'b1, good(b), rdy, 1'b0);
   endtask

   // Monitor: a byte is consumed on the edge after a negedge with VALID & READY.
   initial begin
      forever begin
         @(negedge CLK);
         if (!RST && DOUT_VALID && DOUT_READY) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected: got %0h expected none", DOUT);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (DOUT !== e) begin
                  errors++;
                  $display("FAIL pop_data: got %0h expected %0h", DOUT, e);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rnd;
      int unsigned cnt_violations;

      RST = 1'b1; RX_DATA_EN = 1'b0; RX_DATA_T = '0; DOUT_READY = 1'b0; ERR_CLR = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_count", COUNT, 0);
      check("rst_valid", DOUT_VALID, 0);
      check("rst_dout", DOUT, 8'h00);
      check("rst_ferr", FRAME_ERR, 0);
      check("rst_ovf", OVERFLOW, 0);
      check("rst_fcnt", FERR_CNT, 0);
      @(negedge CLK); RST = 1'b0;
      @(posedge CLK); #1;

      // Good frame 0x34A carries 0xA5.
      exp_q.push_back(8'hA5);
      drive(1'b1, 10'h34A, 1'b0, 1'b0);
      check("t1_valid", DOUT_VALID, 1);
      check("t1_dout", DOUT, 8'hA5);
      check("t1_count", COUNT, 1);
      check("t1_ferr", FRAME_ERR, 0);
      drive(1'b0, 10'h000, 1'b1, 1'b0);
      check("t1_count_drained", COUNT, 0);
      drive(1'b0, 10'h34A, 1'b0, 1'b0);
      check("t1_no_strobe", COUNT, 0);

      // Framing errors and saturation.
      drive(1'b1, 10'h0CA, 1'b0, 1'b0);
      check("t2_count", COUNT, 0);
      check("t2_valid", DOUT_VALID, 0);
      check("t2_ferr", FRAME_ERR, 1);
      check("t2_fcnt1", FERR_CNT, 1);
      for (int i = 1; i < 300; i++)
         drive(1'b1, (i % 2) ? 10'h001 : 10'h3FF, 1'b0, 1'b0);
      check("t2_fcnt_sat", FERR_CNT, 255);
      check("t2_count_after", COUNT, 0);
      drive(1'b0, 10'h000, 1'b0, 1'b1);
      check("t2_clr_ferr", FRAME_ERR, 0);
      check("t2_clr_fcnt", FERR_CNT, 0);
      check("t2_clr_ovf", OVERFLOW, 0);
      drive(1'b1, 10'h0CA, 1'b0, 1'b1);
      check("t2_clr_vs_err_flag", FRAME_ERR, 1);
      check("t2_clr_vs_err_cnt", FERR_CNT, 1);
      drive(1'b0, 10'h000, 1'b0, 1'b1);

      // Fill to depth, then overflow.
      for (int i = 0; i < 16; i++) push_good(8'(i), 1'b0);
      check("t3_full", COUNT, 16);
      check("t3_head", DOUT, 8'h00);
      drive(1'b1, good(8'h10), 1'b0, 1'b0);
      check("t3_ovf", OVERFLOW, 1);
      check("t3_count_kept", COUNT, 16);
      drive(1'b0, 10'h000, 1'b0, 1'b1);
      check("t3_ovf_clr", OVERFLOW, 0);
      drive(1'b1, good(8'h11), 1'b0, 1'b1);
      check("t3_clr_vs_drop", OVERFLOW, 1);
      check("t3_ferr_clean", FRAME_ERR, 0);
      drive(1'b0, 10'h000, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) drive(1'b0, 10'h000, 1'b1, 1'b0);
      check("t3_drained", COUNT, 0);
      check("t3_queue_empty", exp_q.size(), 0);

      // Full FIFO with simultaneous pop and push.
      for (int i = 0; i < 16; i++) push_good(8'(i), 1'b0);
      push_good(8'h55, 1'b1);
      check("t4_count", COUNT, 16);
      check("t4_ovf", OVERFLOW, 0);
      check("t4_head", DOUT, 8'h01);
      for (int i = 0; i < 16; i++) drive(1'b0, 10'h000, 1'b1, 1'b0);
      check("t4_drained", COUNT, 0);
      check("t4_queue_empty", exp_q.size(), 0);

      // Back-to-back strobes with continuous drain.
      cnt_violations = 0;
      for (int i = 0; i < 40; i++) begin
         rnd = 8'($urandom_range(0, 255));
         push_good(rnd, 1'b1);
         if (COUNT > 5'd1) cnt_violations++;
      end
      check("t5_count_le1", cnt_violations, 0);
      drive(1'b0, 10'h000, 1'b1, 1'b0);
      check("t5_drained", COUNT, 0);
      check("t5_ferr", FRAME_ERR, 0);
      check("t5_ovf", OVERFLOW, 0);
      check("t5_queue_empty", exp_q.size(), 0);

      // Asynchronous reset with data stored.
      for (int i = 0; i < 5; i++) push_good(8'hE0 + 8'(i), 1'b0);
      check("t6_count5", COUNT, 5);
      #2;
      RST = 1'b1;
      RX_DATA_EN = 1'b1;
      RX_DATA_T = good(8'hEE);
      exp_q.delete();
      #1;
      check("t6_async_count", COUNT, 0);
      check("t6_async_valid", DOUT_VALID, 0);
      @(posedge CLK); #1;
      check("t6_en_in_reset", COUNT, 0);
      @(negedge CLK);
      RST = 1'b0;
      RX_DATA_EN = 1'b0;
      @(posedge CLK); #1;
      push_good(8'h3C, 1'b0);
      check("t6_first_count", COUNT, 1);
      check("t6_first_dout", DOUT, 8'h3C);
      drive(1'b0, 10'h000, 1'b1, 1'b0);
      check("t6_alone", DOUT_VALID, 0);
      check("t6_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
